multdiv_unit: RTL and testbench

Sequential 32-bit signed multiply/divide responder for the processor core.
- The pipeline (initiator) pulses ctrl_MULT or ctrl_DIV with operands. This block iterates one bit per cycle.
- It returns the result with a one-cycle data_resultRDY pulse.
- The pipeline stalls on this handshake. Operand/result registers are built from the team's enable-gated flip-flop style, but with synchronous reset.

---
 rtl/multdiv_unit.sv | 147 ++++++++++++++
 tb/tb_multdiv_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Sequential signed multiply/divide unit: one iteration per clock, shift-add multiply
// and restoring divide on operand magnitudes, with a one-cycle result-ready pulse.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL_RUN = 2'd1;
  localparam logic [1:0] S_DIV_RUN = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int unsigned   CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ('0 - v) : v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;

  // work_q holds {partial product high, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide; mag_q is the addend/divisor.
  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mag_q} : '0);
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_q};
    div_diff  = div_shift[WIDTH-1:0] - mag_q;
    prod_s    = neg_q ? ('0 - work_q) : work_q;
    quo_s     = neg_q ? ('0 - work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    case (state_q)
      S_MUL_RUN: begin
        if (cnt_q == CNT_LAST) begin
          result_d = prod_s[WIDTH-1:0];
          exc_d    = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
          rdy_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          work_d = {mul_sum, work_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_DIV_RUN: begin
        if (mag_q == '0) begin
          result_d = '0;
          exc_d    = 1'b1;
          rdy_d    = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = quo_s;
          // Only |min| / 1 with matching signs yields an unrepresentable positive quotient.
          exc_d    = !neg_q && work_q[WIDTH-1];
          rdy_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          work_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A start from any state aborts whatever was in flight, including a same-edge finish.
    if (ctrl_MULT || ctrl_DIV) begin
      cnt_d    = '0;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
      if (ctrl_MULT) begin
        mag_d   = mag_of(data_operandA);
        work_d  = {{WIDTH{1'b0}}, mag_of(data_operandB)};
        state_d = S_MUL_RUN;
      end else begin
        mag_d   = mag_of(data_operandB);
        work_d  = {{WIDTH{1'b0}}, mag_of(data_operandA)};
        state_d = S_DIV_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit: latency, result, exception,
// abort-by-restart and abort-by-reset behaviour.
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int total = 0;
  int bad   = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a start pulse; returns 1ns after edge E0 with operands scrambled.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Observe a fixed window of edges, recording the first ready pulse and pulse count.
  task automatic watch(input int cycles, output int first, output int npulse,
                       output logic [31:0] res, output logic exc);
    first  = 0;
    npulse = 0;
    res    = '0;
    exc    = 1'b0;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY) begin
        if (npulse == 0) begin
          first = i;
          res   = data_result;
          exc   = data_exception;
        end
        npulse++;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_exc);
    int          first, npulse;
    logic [31:0] res;
    logic        exc;
    issue(m, d, a, b);
    chk({tag, "_busy_e0"}, 64'(busy), 64'(1));
    watch(40, first, npulse, res, exc);
    chk({tag, "_lat"}, 64'(first), 64'(exp_lat));
    chk({tag, "_pulses"}, 64'(npulse), 64'(1));
    chk({tag, "_res"}, 64'(res), 64'(exp_res));
    chk({tag, "_exc"}, 64'(exc), 64'(exp_exc));
    chk({tag, "_hold"}, 64'(data_result), 64'(exp_res));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int          first, npulse;
    logic [31:0] res;
    logic        exc;

    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_result", 64'(data_result), 64'(0));
    chk("rst_exc", 64'(data_exception), 64'(0));
    chk("rst_rdy", 64'(data_resultRDY), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    run_op("mul_7_m3",    1, 0, 32'd7,          32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 1'b0);
    run_op("mul_2p16sq",  1, 0, 32'h0001_0000,  32'h0001_0000, 33, 32'h0000_0000, 1'b1);
    run_op("mul_ovf31",   1, 0, 32'h4000_0000,  32'd2,         33, 32'h8000_0000, 1'b1);
    run_op("mul_min_x1",  1, 0, 32'h8000_0000,  32'd1,         33, 32'h8000_0000, 1'b0);
    run_op("mul_m5_m6",   1, 0, 32'hFFFF_FFFB,  32'hFFFF_FFFA, 33, 32'd30,        1'b0);
    run_op("div_m7_2",    0, 1, 32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFD, 1'b0);
    run_op("div_by0",     0, 1, 32'd5,          32'd0,         1,  32'h0000_0000, 1'b1);
    run_op("div_min_m1",  0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1);
    run_op("div_100_m7",  0, 1, 32'd100,        32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 1'b0);
    run_op("both_6_3",    1, 1, 32'd6,          32'd3,         33, 32'd18,        1'b0);

    // Restart: DIV sampled at E0+10 of a running multiply.
    issue(1, 0, 32'd6, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    run_op("restart_div", 0, 1, 32'd100, 32'd10, 33, 32'd10, 1'b0);

    // Reset sampled at E0+20 of a multiply.
    issue(1, 0, 32'd6, 32'd7);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_result", 64'(data_result), 64'(0));
    chk("abort_exc", 64'(data_exception), 64'(0));
    chk("abort_rdy", 64'(data_resultRDY), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    watch(40, first, npulse, res, exc);
    chk("abort_pulses", 64'(npulse), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
